// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
// Holds the FSM state encoding, the sample-point offsets around the bit
// midpoint, and the 2-of-3 vote used when UART_RX_MAJORITY_EN is defined.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Early sample sits this many edges before the bit midpoint.
  localparam logic [5:0] SMP_EARLY_OFS = 6'd1;
  // Late sample / commit point sits this many edges after the midpoint.
  localparam logic [5:0] SMP_LATE_OFS  = 6'd1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter plus bit index for the UART receiver.
// edge_cnt runs 0..prescale-1 inside a bit; on wrap the bit index advances.
// Both clear on restart (new frame) and are held at zero while not running.
module edge_bit_counter #(
  parameter int BCW = 4
) (
  input  logic           gclk,
  input  logic           grst,
  input  logic           restart,
  input  logic           run,
  input  logic [5:0]     prescale,
  output logic [5:0]     edge_cnt,
  output logic [BCW-1:0] bit_cnt,
  output logic           last_edge
);

  assign last_edge = (edge_cnt == prescale - 6'd1);

  // Edge count within a bit, bit index within the frame.
  always_ff @(posedge gclk) begin
    if (grst || restart || !run) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (last_edge) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BCW'(1);
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing with per-frame latched
// prescale and parity settings, one-cycle result pulses.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 vote of
// samples around the midpoint instead of the single midpoint sample.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int data_width = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       RX_IN,
  input  logic                       PAR_EN,
  input  logic                       PAR_TYP,
  input  logic [5:0]                 Prescale,
  output logic [2**data_width-1:0]   P_DATA,
  output logic                       data_valid,
  output logic                       par_err,
  output logic                       stp_err
);

  localparam int NBITS = 2 ** data_width;
  // Bit index covers start + data + parity + stop.
  localparam int BCW   = $clog2(NBITS + 4);

  rx_state_e        state, next_state;
  logic [5:0]       presc_q;
  logic             par_en_q, par_typ_q;
  logic [5:0]       edge_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic             last_edge;
  logic             start_frame;
  logic             active;
  logic [5:0]       mid_pt, commit_pt;
  logic             smp_mid, commit_bit, bit_val, par_bad;
  logic [NBITS-1:0] shreg;
  logic             dv_n, pe_n, se_n;

  assign active    = (state != IDLE);
  assign mid_pt    = {1'b0, presc_q[5:1]};
  assign commit_pt = mid_pt + SMP_LATE_OFS;

  edge_bit_counter #(.BCW(BCW)) u_cnt (
    .gclk      (CLK),
    .grst      (RST),
    .restart   (start_frame),
    .run       (active),
    .prescale  (presc_q),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .last_edge (last_edge)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [5:0] early_pt;
  logic       smp_early;
  assign early_pt = mid_pt - SMP_EARLY_OFS;

  // Capture the early vote sample one edge before the midpoint.
  always_ff @(posedge CLK) begin
    if (RST)                                smp_early <= 1'b0;
    else if (active && edge_cnt == early_pt) smp_early <= RX_IN;
  end

  // Third vote is the live line value at the commit edge.
  assign commit_bit = maj3(smp_early, smp_mid, RX_IN);
`else
  assign commit_bit = smp_mid;
`endif

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next state, frame-start strobe and result pulses; all decisions at bit end.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    dv_n        = 1'b0;
    pe_n        = 1'b0;
    se_n        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!RX_IN) begin
          next_state  = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        // A start bit that reads high was a glitch.
        if (last_edge) next_state = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (last_edge && bit_cnt == BCW'(NBITS))
          next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (last_edge) next_state = STOP;
      end
      STOP: begin
        if (last_edge) begin
          if (!bit_val)     se_n = 1'b1;
          else if (par_bad) pe_n = 1'b1;
          else              dv_n = 1'b1;
          // Line already low: next start bit begins right now.
          if (!RX_IN) begin
            next_state  = START;
            start_frame = 1'b1;
          end else begin
            next_state  = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Config latch, sampler, deserializer, parity check and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      smp_mid    <= 1'b0;
      bit_val    <= 1'b0;
      par_bad    <= 1'b0;
      shreg      <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      if (start_frame) begin
        presc_q   <= Prescale;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_bad   <= 1'b0;
      end
      if (active && edge_cnt == mid_pt) smp_mid <= RX_IN;
      if (active && edge_cnt == commit_pt) begin
        bit_val <= commit_bit;
        if (state == DATA)   shreg   <= {commit_bit, shreg[NBITS-1:1]};
        if (state == PARITY) par_bad <= (commit_bit != ((^shreg) ^ par_typ_q));
      end
      if (dv_n) P_DATA <= shreg;
      data_valid <= dv_n;
      par_err    <= pe_n;
      stp_err    <= se_n;
    end
  end

endmodule
